i2c_master_rd: RTL
==================

Name: i2c_master_rd

Overview:
- Bus-side read master that sits directly upstream of the i2c_slave on the same scl/sda wires.
- Issues START, then the 7-bit address with R/W=1, then reads N bytes the slave shifts out of its tx FIFO, ACKing every byte but the last, which is NACKed, then issues STOP.
- Delivers received bytes on a one-cycle valid strobe.
- Serves as the bus driver for the lab's slave test benches and for the system-level loopback.

Parameters:
- SLAVE_ADDR, 7'b1111000, 7-bit target address; address byte on wire = {SLAVE_ADDR,1'b1}.
- CLK_DIV, 4, clk cycles per SCL quarter-period (Q); legal range 4..255.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- n_rst  input  1  synchronous, active-high reset: 1 = reset, sampled on rising clk.
- start  input  1  begin a read transaction; honoured only when busy=0.
- num_bytes  input  8  bytes to read; captured on the accepted start cycle.
- sda_in  input  1  wired-AND bus SDA value.
- scl  output  1  SCL drive; 1 = released/high.
- sda_out  output  1  SDA drive; 1 = released, 0 = pull low.
- rx_data  output  8  last received byte, MSB first on the wire.
- rx_valid  output  1  one-cycle pulse, rx_data newly valid.
- busy  output  1  transaction in progress.
- done  output  1  one-cycle pulse at transaction end.
- nack_err  output  1  address NACKed in the last transaction; cleared on next accepted start.

Behaviour:
- Reset values: scl=1, sda_out=1, rx_data=0, rx_valid=0, busy=0, done=0, nack_err=0, FSM=IDLE.
- Reset mid-transaction: the next cycle has all reset values. Bus is released, no STOP is generated, and no done pulse is issued.
- Quarter counter counts 0..CLK_DIV-1. Each bit slot is 4 quarters, q0..q3, so the bit period is 4*CLK_DIV clocks.
- Bit slot timing:
  - q0,q1: scl=0.
  - q2,q3: scl=1.
  - sda_out updates on the first clock of q1.
  - sda_in is sampled on the last clock of q2.
- FSM states: IDLE, START, ADDR, ADDR_ACK, READ, MACK, STOP, DONE.
- IDLE: scl=1, sda_out=1. start=1 moves to START, captures num_bytes, clears nack_err, and sets busy=1 the next cycle. start while busy is ignored.
- START: sda_out=0 with scl=1 for 2Q, then go to ADDR.
- ADDR: 8 slots shifting {SLAVE_ADDR,1}, MSB first.
- ADDR_ACK: 1 slot, sda_out=1.
  - Sampled 0 (ACK): go to READ, or to STOP if num_bytes=0.
  - Sampled 1 (NACK): set nack_err=1 and go to STOP.
- READ: 8 slots with sda_out=1, shifting sda_in into a shift register, MSB first.
  - On the 8th sample cycle, rx_data takes the full byte and rx_valid=1 for exactly that cycle.
  - The remaining-byte counter then decrements.
- MACK: 1 slot.
  - Counter != 0: sda_out=0 (ACK), then go to READ.
  - Counter == 0: sda_out=1 (NACK), then go to STOP.
- STOP sequence, 6Q total:
  - 2Q with scl=0, sda_out=0.
  - 2Q with scl=1, sda_out=0.
  - sda_out=1, then 2Q bus-free hold.
  - Then go to DONE.
- DONE: 1 cycle with done=1 and busy=0, then IDLE. busy deasserts in the same cycle done rises.
- Total clocks from the accepted start cycle to the done pulse = 2Q + (9 + 9*num_bytes)*4Q + 6Q.
- Counters:
  - Byte counter: 8-bit, no wrap; it stops at 0.
  - Bit counter: 3-bit, counts 0..7.
  - Quarter counter: 8-bit.
- scl is never stretched: the master ignores the bus SCL value, and there is no clock-stretching support.
- The sda_in value sampled during this block's own drive slots (START, ADDR, ACK) is not checked; there is no arbitration.

Test Plan:
- Reset: hold n_rst=1 for 3 clks with start=1 -> scl=1, sda_out=1, busy=0, rx_valid=0, done=0, nack_err=0 throughout.
- Read 2 bytes, CLK_DIV=4, slave model ACKs 0xF1 and returns 0xA5 then 0x3C:
  - Required: rx_valid pulses exactly twice, with rx_data=0xA5 then 0x3C.
  - sda_out=0 in the first MACK slot and 1 in the second.
  - STOP edge is observed; done arrives 8+27*16+24=464 clks after start; nack_err=0.
- Address NACK (bus sda high in the ADDR_ACK slot):
  - Required: nack_err=1, no rx_valid, STOP is generated, done after 8+9*16+24=176 clks.
  - The next start clears nack_err.
- num_bytes=0 with ACK:
  - Required: address byte, then STOP, no rx_valid, done after 176 clks.
  - A start pulse mid-transaction is ignored: single done, unchanged timing.
- Reset asserted during the 4th READ bit -> the next cycle has scl=1, sda_out=1, busy=0, no done. A fresh start then completes normally.
- Bit timing, CLK_DIV=4:
  - Every scl low and high phase measures 8 clks.
  - Every sda_out change occurs only while scl=0, except the START and STOP edges, which occur with scl=1.

Source files
------------

// File: rtl/i2c_master_rd.sv
// I2C read master: drives START, the address byte {SLAVE_ADDR,1}, then reads
// num_bytes bytes from the addressed slave. Every byte is ACKed except the last,
// which is NACKed. The transfer ends with STOP.
//
// Ports:
//   clk        system clock, rising edge
//   n_rst      synchronous active-high reset
//   start      request a read; accepted only in idle
//   num_bytes  byte count, captured with the accepted start
//   sda_in     wired-AND SDA as seen on the bus
//   scl        SCL drive (1 = released)
//   sda_out    SDA drive (1 = released, 0 = pull low)
//   rx_data    last received byte
//   rx_valid   one-cycle strobe, rx_data newly valid
//   busy       transaction in progress
//   done       one-cycle strobe at transaction end
//   nack_err   address was NACKed in the last transaction
//
// Each bit slot has four quarters of CLK_DIV clocks. SCL is low in q0/q1 and
// high in q2/q3. SDA changes at the start of q1 and is sampled on the last
// clock of q2. Legal CLK_DIV range is 4..255.
module i2c_master_rd #(
  parameter logic [6:0]  SLAVE_ADDR = 7'b1111000,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic [7:0] num_bytes,
  input  logic       sda_in,
  output logic       scl,
  output logic       sda_out,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic       nack_err
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StAddr,
    StAddrAck,
    StRead,
    StMack,
    StStop,
    StDone
  } state_e;

  localparam logic [7:0] QLast    = 8'(CLK_DIV - 1);
  localparam logic [7:0] AddrByte = {SLAVE_ADDR, 1'b1};

  state_e     state_q, state_d;
  logic [7:0] qcnt_q, qcnt_d;         // clocks within the current quarter
  logic [2:0] qidx_q, qidx_d;         // quarter index within the current slot/phase
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       ack_q, ack_d;           // sampled address-ACK bit (0 = ACK)
  logic       scl_q, scl_d;
  logic       sda_q, sda_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       nack_q, nack_d;

  logic       timed;
  logic       q_end;
  logic       slot_end;
  logic       drive_upd;
  logic       sample;
  logic [2:0] last_qidx;

  // Quarter bookkeeping shared by all timed states.
  always_comb begin
    last_qidx = 3'd3;
    if (state_q == StStart) begin
      last_qidx = 3'd1;
    end else if (state_q == StStop) begin
      last_qidx = 3'd5;
    end
    timed     = state_q inside {StStart, StAddr, StAddrAck, StRead, StMack, StStop};
    q_end     = timed && (qcnt_q == QLast);
    slot_end  = q_end && (qidx_q == last_qidx);
    drive_upd = q_end && (qidx_q == 3'd0);  // next clock is the first of q1
    sample    = q_end && (qidx_q == 3'd2);  // last clock of q2
  end

  always_comb begin
    state_d    = state_q;
    qcnt_d     = qcnt_q;
    qidx_d     = qidx_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    ack_d      = ack_q;
    sda_d      = sda_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    nack_d     = nack_q;
    scl_d      = 1'b1;

    if (timed) begin
      if (q_end) begin
        qcnt_d = 8'd0;
        qidx_d = slot_end ? 3'd0 : qidx_q + 3'd1;
      end else begin
        qcnt_d = qcnt_q + 8'd1;
      end
    end

    case (state_q)
      StIdle: begin
        sda_d = 1'b1;
        if (start) begin
          state_d    = StStart;
          byte_cnt_d = num_bytes;
          nack_d     = 1'b0;
          bit_cnt_d  = 3'd0;
          qcnt_d     = 8'd0;
          qidx_d     = 3'd0;
          sda_d      = 1'b0;  // START: SDA falls while SCL is high
        end
      end
      StStart: begin
        if (slot_end) begin
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (drive_upd) begin
          sda_d = AddrByte[3'd7 - bit_cnt_q];
        end
        if (slot_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StAddrAck;
          end
        end
      end
      StAddrAck: begin
        if (drive_upd) begin
          sda_d = 1'b1;
        end
        if (sample) begin
          ack_d = sda_in;
          if (sda_in) begin
            nack_d = 1'b1;
          end
        end
        if (slot_end) begin
          state_d = (ack_q || (byte_cnt_q == 8'd0)) ? StStop : StRead;
        end
      end
      StRead: begin
        if (drive_upd) begin
          sda_d = 1'b1;
        end
        if (sample) begin
          shift_d = {shift_q[6:0], sda_in};
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = {shift_q[6:0], sda_in};
            rx_valid_d = 1'b1;
            if (byte_cnt_q != 8'd0) begin
              byte_cnt_d = byte_cnt_q - 8'd1;
            end
          end
        end
        if (slot_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StMack;
          end
        end
      end
      StMack: begin
        // ACK while more bytes remain, NACK the final byte.
        if (drive_upd) begin
          sda_d = (byte_cnt_q == 8'd0);
        end
        if (slot_end) begin
          state_d = (byte_cnt_q == 8'd0) ? StStop : StRead;
        end
      end
      StStop: begin
        // q0 scl low/sda held, q1 sda low, q2-q3 scl high, q4 sda release, q5 bus free.
        if (drive_upd) begin
          sda_d = 1'b0;
        end
        if (q_end && (qidx_q == 3'd3)) begin
          sda_d = 1'b1;
        end
        if (slot_end) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // SCL follows the quarter that the next cycle will be in.
    if (state_d inside {StAddr, StAddrAck, StRead, StMack, StStop}) begin
      scl_d = qidx_d[2] | qidx_d[1];
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q    <= StIdle;
      qcnt_q     <= 8'd0;
      qidx_q     <= 3'd0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 8'd0;
      shift_q    <= 8'd0;
      ack_q      <= 1'b0;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      qidx_q     <= qidx_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      ack_q      <= ack_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      nack_q     <= nack_d;
    end
  end

  assign scl      = scl_q;
  assign sda_out  = sda_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign nack_err = nack_q;
  assign busy     = (state_q != StIdle) && (state_q != StDone);
  assign done     = (state_q == StDone);

endmodule
